// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and elaboration-time helpers for the parametrised
// synchronous FIFO: read-mode selectors and pointer/address width functions.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FWFT_OFF = 0;  // registered read, 1-cycle latency
  localparam int FWFT_ON  = 1;  // head entry shown on data_out while non-empty

  // Memory address width for a given depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width: one extra MSB beyond the address so that a full FIFO
  // (pointers differ by DEPTH) is distinguishable from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// Simple dual-port storage array, DATA_W x DEPTH.
// Synchronous write on the rising clock edge, asynchronous (combinational)
// read. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds, overflow/underflow pulses and an optional
// first-word-fall-through read mode.
//   clk          : clock, all logic on rising edge
//   rst          : synchronous active-high reset
//   wr_en        : write request, accepted when !full
//   data_in      : write data
//   rd_en        : read request (pop in FWFT mode), accepted when !empty
//   data_out     : read data (registered, or head entry in FWFT mode)
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy, 0..DEPTH
//   overflow     : one-cycle pulse after a write request while full
//   underflow    : one-cycle pulse after a read request while empty
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_sync_param: DATA_W must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_fwft
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic              wr_acc, rd_acc, mem_we;
  logic [DATA_W-1:0] rd_data, dout_q;

  // Requests are qualified by the registered flags of the current cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign mem_we = wr_acc && !rst;

  // Occupancy is the pointer distance; the extra MSB keeps DEPTH distinct
  // from 0, so the modular subtraction is exact over 0..DEPTH.
  always_comb begin
    wr_ptr_nxt = wr_ptr + {{(PTR_W-1){1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{(PTR_W-1){1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_q       <= '0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
      if (rd_acc) begin
        dout_q <= rd_data;
      end
    end
  end

  // In FWFT mode the head entry is shown directly while non-empty; when empty
  // the output falls back to the last registered value (zero after reset).
  assign data_out = (FWFT == FWFT_ON && !empty) ? rd_data : dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, empty_s, af_s, ae_s, ov_s, un_s;
  logic          full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [CW-1:0] cnt_s, cnt_f;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ov_s), .underflow(un_s)
  );

  fifo_sync_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ov_f), .underflow(un_f)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus the expected registered
  // read word and error pulses.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  bit            exp_ov   = 1'b0;
  bit            exp_un   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_s", 32'(cnt_s),   32'(n));
    chk("full_s",  32'(full_s),  32'(n == DEPTH));
    chk("empty_s", 32'(empty_s), 32'(n == 0));
    chk("af_s",    32'(af_s),    32'(n >= AF));
    chk("ae_s",    32'(ae_s),    32'(n <= AE));
    chk("ov_s",    32'(ov_s),    32'(exp_ov));
    chk("un_s",    32'(un_s),    32'(exp_un));
    chk("dout_s",  32'(dout_s),  32'(exp_dout));
    chk("count_f", 32'(cnt_f),   32'(n));
    chk("full_f",  32'(full_f),  32'(n == DEPTH));
    chk("empty_f", 32'(empty_f), 32'(n == 0));
    chk("af_f",    32'(af_f),    32'(n >= AF));
    chk("ae_f",    32'(ae_f),    32'(n <= AE));
    chk("ov_f",    32'(ov_f),    32'(exp_ov));
    chk("un_f",    32'(un_f),    32'(exp_un));
    if (n > 0) chk("head_f", 32'(dout_f), 32'(q[0]));
  endtask

  // One clock cycle: apply inputs, advance the model by the same edge, check.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    bit was_full, was_empty;
    rst = r; wr_en = w; data_in = d; rd_en = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_dout = '0;
      exp_ov   = 1'b0;
      exp_un   = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_ov = w && was_full;
      exp_un = rd && was_empty;
      if (rd && !was_empty) exp_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

    // Reset state
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("rst_dout_f", 32'(dout_f), 32'h0);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 16; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hFF, 0);
    chk("ovf_pulse", 32'(ov_s), 32'h1);
    step(0, 0, 8'h00, 0);

    // Drain in order, plus one read while empty
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 8'h00, 1);
      chk("drain_order", 32'(dout_s), 32'(i));
    end
    step(0, 0, 8'h00, 1);
    chk("unf_hold", 32'(dout_s), 32'h10);
    chk("unf_pulse", 32'(un_s), 32'h1);

    // Simultaneous write/read at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1);
    chk("wrap_count", 32'(cnt_s), 32'd5);

    // FWFT: write to empty is visible next cycle, pop empties it
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'hA5, 0);
    chk("fwft_a5", 32'(dout_f), 32'hA5);
    chk("fwft_nonempty", 32'(empty_f), 32'h0);
    step(0, 0, 8'h00, 1);
    chk("fwft_pop_empty", 32'(empty_f), 32'h1);
    chk("fwft_pop_count", 32'(cnt_f), 32'h0);

    // Reset mid-stream at count 9
    for (int i = 0; i < 9; i++) step(0, 1, 8'($urandom), 0);
    chk("pre_rst_count", 32'(cnt_s), 32'd9);
    step(1, 1, 8'h77, 1);
    chk("mid_rst_count", 32'(cnt_s), 32'd0);
    chk("mid_rst_empty", 32'(empty_s), 32'h1);
    step(0, 1, 8'h3C, 0);
    chk("post_rst_head_f", 32'(dout_f), 32'h3C);
    step(0, 0, 8'h00, 1);
    chk("post_rst_read", 32'(dout_s), 32'h3C);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 55),
           8'($urandom),
           ($urandom_range(0, 99) < 50));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO that generalises the team's fixed 8-bit FIFO to configurable data width and depth. It adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in one clock domain and is the default buffering primitive for new datapaths.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request (pop in FWFT mode)
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested while full
- underflow  out  1  one-cycle pulse: read requested while empty

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty; flags sampled are the registered values from the same edge.
- Full with wr_en && rd_en: read accepted, write rejected, overflow pulses. Empty with both: write accepted, read rejected, underflow pulses.
- Pointers are $clog2(DEPTH)+1 bits; the low bits address memory, wrap naturally at DEPTH, and the MSB distinguishes full from empty.
- count: +1 on accepted write only, −1 on accepted read only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- All status flags are registered and computed from next-state count, so they always agree with count in the same cycle.
- Standard mode: accepted read registers mem[rd_ptr] into data_out; otherwise data_out holds its previous value.
- FWFT mode: data_out shows the head entry whenever !empty; rd_en pops it and the next entry appears after the same edge. data_out is don't-care while empty.
- Rejected requests leave pointers, count and memory unchanged.

## Timing
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0 (AF_THRESH ≥ 1), overflow 0, underflow 0, data_out 0.
- Reset mid-operation discards all contents on that edge. The memory array is not cleared.
- Standard read latency: data_out is valid on the edge after rd_en is accepted, i.e. 1 cycle.
- FWFT: a write into an empty FIFO is visible on data_out and empty=0 in the cycle after the write edge.
- Write to read-visibility latency: 1 cycle (empty deasserts 1 cycle after the first accepted write).
- overflow and underflow assert for exactly the cycle following the offending request edge.

## Structure
- Package fifo_pkg holds the ptr/count width helper functions and the FWFT mode constants.
- Sub-module fifo_mem: simple dual-port RAM, DATA_W × DEPTH, synchronous write, asynchronous read. The top-level registers output in standard mode and muxes the head entry for FWFT.
- Elaboration-time assertions check that DEPTH is a power of two and that the thresholds are in range.

## Test plan
- Reset, DATA_W=8, DEPTH=16 -> empty=1, almost_empty=1, count=0, data_out=0, no error pulses.
- Write 16 words 0x01..0x10, then a 17th (0xFF) -> full=1, count=16, almost_full from count=14, overflow pulses once, 0xFF never read.
- Read 16 words in standard mode -> data_out 0x01..0x10 in order, each 1 cycle after rd_en; an extra read gives underflow=1 and data_out holds 0x10.
- Continuous simultaneous write/read at count=5 for 40 cycles (pointer wrap) -> count stays 5, data order preserved across the wrap.
- FWFT=1: write 0xA5 to empty -> next cycle data_out=0xA5, empty=0; rd_en pops -> empty=1, count=0.
- Assert rst at count=9 mid-stream -> next cycle count=0, empty=1; a subsequent write of 0x3C is read back as 0x3C.
